// File: rtl/decompress_ctrl.sv
// decompress_ctrl: expands an alternating run-length stream (zeros first)
// into LSB-first packed words, stops after a programmed bit count and
// pulses Done. Output word sits in a registered valid/ready holding stage.
module decompress_ctrl #(
   parameter int WORD_W = 16,
   parameter int LEN_W  = 16,
   parameter int TOT_W  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Start,
   input  logic [TOT_W-1:0]  TotalBits,
   input  logic [LEN_W-1:0]  RunIn,
   input  logic              RunValid,
   output logic              RunReady,
   output logic [WORD_W-1:0] DataOut,
   output logic              OutValid,
   input  logic              OutReady,
   output logic              Busy,
   output logic              Done,
   output logic              Error
);

   localparam int FW = $clog2(WORD_W + 1);

   typedef enum logic [2:0] {IDLE, FETCH, EXPAND, FLUSH, DONE} state_t;

   state_t            state, state_n;
   logic [TOT_W-1:0]  rem, rem_n;
   logic [LEN_W-1:0]  run, run_n;
   logic              digit, digit_n;
   logic [WORD_W-1:0] acc, acc_n, dout_n;
   logic [FW-1:0]     fill, fill_n;
   logic              ovalid_n, err_n;

   logic              out_free;
   logic [LEN_W:0]    space, n;
   logic [WORD_W-1:0] mask, packed_w;
   logic              word_full;

   assign RunReady = (state == FETCH);
   assign Busy     = (state != IDLE);
   assign Done     = (state == DONE);

   // State and datapath registers; reset abandons any transfer in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rem      <= '0;
         run      <= '0;
         digit    <= 1'b0;
         acc      <= '0;
         fill     <= '0;
         DataOut  <= '0;
         OutValid <= 1'b0;
         Error    <= 1'b0;
      end else begin
         state    <= state_n;
         rem      <= rem_n;
         run      <= run_n;
         digit    <= digit_n;
         acc      <= acc_n;
         fill     <= fill_n;
         DataOut  <= dout_n;
         OutValid <= ovalid_n;
         Error    <= err_n;
      end
   end

   // Next-state and datapath: one EXPAND cycle retires min(run, free slots) bits.
   always_comb begin
      state_n  = state;
      rem_n    = rem;
      run_n    = run;
      digit_n  = digit;
      acc_n    = acc;
      fill_n   = fill;
      dout_n   = DataOut;
      err_n    = Error;
      // Holding register drains on acceptance; a reload below overrides this.
      out_free = !OutValid || OutReady;
      ovalid_n = OutValid && !OutReady;

      // n is one bit wider than a run so the min never truncates.
      space = (LEN_W+1)'(WORD_W) - (LEN_W+1)'(fill);
      n     = ({1'b0, run} < space) ? {1'b0, run} : space;
      mask  = '0;
      for (int i = 0; i < WORD_W; i++)
         mask[i] = (i >= int'(fill)) && (i < int'(fill) + int'(n));
      // Acc bits above Fill are always zero, so only ones need writing.
      packed_w  = digit ? (acc | mask) : acc;
      word_full = (n == space);

      case (state)
         IDLE: begin
            if (Start) begin
               rem_n   = TotalBits;
               digit_n = 1'b0;
               fill_n  = '0;
               acc_n   = '0;
               err_n   = 1'b0;
               // An empty transfer passes through FLUSH, which finds nothing to emit.
               state_n = (TotalBits == '0) ? FLUSH : FETCH;
            end
         end
         FETCH: begin
            if (RunValid) begin
               if (RunIn == '0) begin
                  digit_n = ~digit;
               end else begin
                  if (TOT_W'(RunIn) > rem) begin
                     err_n = 1'b1;
                     run_n = LEN_W'(rem);
                  end else begin
                     run_n = RunIn;
                  end
                  state_n = EXPAND;
               end
            end
         end
         EXPAND: begin
            // A finished word with nowhere to go freezes everything.
            if (!word_full || out_free) begin
               run_n = run - LEN_W'(n);
               rem_n = rem - TOT_W'(n);
               if (word_full) begin
                  dout_n   = packed_w;
                  ovalid_n = 1'b1;
                  acc_n    = '0;
                  fill_n   = '0;
               end else begin
                  acc_n  = packed_w;
                  fill_n = fill + FW'(n);
               end
               if (rem_n == '0) begin
                  state_n = FLUSH;
               end else if (run_n == '0) begin
                  digit_n = ~digit;
                  state_n = FETCH;
               end
            end
         end
         FLUSH: begin
            if (fill != '0) begin
               if (out_free) begin
                  dout_n   = acc;
                  ovalid_n = 1'b1;
                  acc_n    = '0;
                  fill_n   = '0;
               end
            end else if (out_free) begin
               state_n = DONE;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_decompress_ctrl.sv
// Scoreboard bench for decompress_ctrl: a bit-level reference model fills
// the expected-word queue; an independent monitor pops on each output handshake.
module tb_decompress_ctrl;

   localparam int WORD_W = 16;
   localparam int LEN_W  = 16;
   localparam int TOT_W  = 20;

   logic              clk = 1'b0;
   logic              rst;
   logic              Start;
   logic [TOT_W-1:0]  TotalBits;
   logic [LEN_W-1:0]  RunIn;
   logic              RunValid;
   logic              RunReady;
   logic [WORD_W-1:0] DataOut;
   logic              OutValid;
   logic              OutReady;
   logic              Busy;
   logic              Done;
   logic              Error;

   decompress_ctrl #(.WORD_W(WORD_W), .LEN_W(LEN_W), .TOT_W(TOT_W)) dut (
      .clk(clk), .rst(rst), .Start(Start), .TotalBits(TotalBits),
      .RunIn(RunIn), .RunValid(RunValid), .RunReady(RunReady),
      .DataOut(DataOut), .OutValid(OutValid), .OutReady(OutReady),
      .Busy(Busy), .Done(Done), .Error(Error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   logic [WORD_W-1:0] exp_q[$];
   int                runs_q[$];
   bit                exp_err;
   int                rmode;      // 0 ready, 1 random, 2 never, 3 stall 10 after first valid
   int                stl;
   bit                stall_done;
   bit                mon_en;
   int                done_cnt, done_cyc, hs_cyc;
   bit                prev_stall;
   logic [WORD_W-1:0] prev_d;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: walk the runs bit by bit, pack LSB first, pad the tail with zeros.
   function automatic void model(input int tb);
      int rem = tb;
      int fm = 0;
      int r;
      bit d = 1'b0;
      logic [WORD_W-1:0] w = '0;
      exp_err = 1'b0;
      foreach (runs_q[k]) begin
         if (rem == 0) break;
         r = runs_q[k];
         if (r == 0) begin
            d = !d;
            continue;
         end
         if (r > rem) begin
            exp_err = 1'b1;
            r = rem;
         end
         for (int j = 0; j < r; j++) begin
            w[fm] = d;
            fm++;
            if (fm == WORD_W) begin
               exp_q.push_back(w);
               w = '0;
               fm = 0;
            end
         end
         rem -= r;
         d = !d;
      end
      if (fm > 0) exp_q.push_back(w);
   endfunction

   // Consumer-side OutReady pattern.
   initial begin
      OutReady = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0: OutReady = 1'b1;
            1: OutReady = 1'($urandom_range(0, 1));
            2: OutReady = 1'b0;
            default: begin
               if (OutValid && !stall_done) begin
                  OutReady = 1'b0;
                  stl++;
                  if (stl >= 10) stall_done = 1'b1;
               end else begin
                  OutReady = 1'b1;
               end
            end
         endcase
      end
   end

   // Monitor: pops the scoreboard on every output handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (rst || !mon_en) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               chk("hold", {15'd0, OutValid, DataOut}, {15'd0, 1'b1, prev_d});
            if (OutValid && OutReady) begin
               if (exp_q.size() == 0) begin
                  chk("extra_word", {16'd0, DataOut}, 32'hdead);
               end else begin
                  chk("word", {16'd0, DataOut}, {16'd0, exp_q.pop_front()});
               end
               hs_cyc = cyc;
            end
            if (!Busy && OutValid) chk("idle_valid", OutValid, 0);
            if (rmode == 3 && stl >= 6 && !stall_done) chk("stall_runready", RunReady, 0);
            if (Done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            prev_stall = OutValid && !OutReady;
            prev_d     = DataOut;
         end
      end
   end

   task automatic xfer(input int tb, input int mode, input bit glitch);
      int  sc;
      int  d;
      bit  ok;
      model(tb);
      stl = 0;
      stall_done = 1'b0;
      rmode = mode;
      done_cnt = 0;
      hs_cyc = -1;
      @(posedge clk); #1;
      Start = 1'b1;
      TotalBits = TOT_W'(tb);
      sc = cyc;
      @(posedge clk); #1;
      Start = 1'b0;
      @(negedge clk);
      chk("start_runready", RunReady, tb != 0);
      chk("err_cleared", Error, 0);
      foreach (runs_q[i]) begin
         d = $urandom_range(0, 2);
         @(posedge clk); #1;
         repeat (d) begin
            @(posedge clk); #1;
         end
         RunValid = 1'b1;
         RunIn = LEN_W'(runs_q[i]);
         if (glitch && i == 1) begin
            Start = 1'b1;
            TotalBits = TOT_W'($urandom);
         end
         ok = 1'b0;
         for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (RunReady) begin
               ok = 1'b1;
               break;
            end
         end
         @(posedge clk); #1;
         RunValid = 1'b0;
         Start = 1'b0;
         if (!ok) begin
            chk("run_timeout", 0, 1);
            break;
         end
         if (runs_q[i] == 0) begin
            @(negedge clk);
            chk("zero_run_1cyc", RunReady, 1);
         end
      end
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge clk);
      chk("done_seen", ok, 1);
      chk("done_once", done_cnt, 1);
      chk("error", Error, exp_err);
      chk("words_left", exp_q.size(), 0);
      chk("idle_after", Busy, 0);
      if (tb == 0) chk("done_lat_empty", done_cyc, sc + 2);
      else         chk("done_lat", done_cyc, hs_cyc + 1);
      exp_q.delete();
      rmode = 0;
   endtask

   // Watchdog.
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int tb, r, rem;
      rst = 1'b1;
      Start = 1'b0;
      TotalBits = '0;
      RunIn = '0;
      RunValid = 1'b0;
      rmode = 0;
      mon_en = 1'b1;
      #12;
      chk("rst_runready", RunReady, 0);
      chk("rst_dataout", DataOut, 0);
      chk("rst_outvalid", OutValid, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_error", Error, 0);
      @(negedge clk);
      rst = 1'b0;

      runs_q = {4, 8, 8};    xfer(20, 0, 0);
      runs_q = {0, 3, 13};   xfer(16, 0, 0);
      runs_q = {16, 16, 16}; xfer(48, 3, 0);
      runs_q = {12};         xfer(10, 0, 0);
      repeat (3) @(negedge clk);
      chk("err_sticky", Error, 1);
      runs_q = {};           xfer(0, 0, 0);
      runs_q = {5, 20, 7};   xfer(32, 1, 1);

      // Asynchronous reset while a ones-run is stalled in EXPAND.
      mon_en = 1'b0;
      rmode = 2;
      @(posedge clk); #1;
      Start = 1'b1;
      TotalBits = 48;
      @(posedge clk); #1;
      Start = 1'b0;
      RunValid = 1'b1;
      RunIn = 0;
      @(posedge clk); #1;
      RunIn = 40;
      @(posedge clk); #1;
      RunValid = 1'b0;
      @(posedge clk); #3;
      chk("pre_rst_valid", {15'd0, OutValid, DataOut}, {15'd0, 1'b1, 16'hffff});
      chk("pre_rst_busy", Busy, 1);
      rst = 1'b1;
      #1;
      chk("arst_dataout", DataOut, 0);
      chk("arst_outvalid", OutValid, 0);
      chk("arst_busy", Busy, 0);
      chk("arst_runready", RunReady, 0);
      chk("arst_done", Done, 0);
      chk("arst_error", Error, 0);
      @(negedge clk);
      rst = 1'b0;
      rmode = 0;
      mon_en = 1'b1;
      runs_q = {16};
      xfer(16, 0, 0);

      // Randomized transfers.
      for (int t = 0; t < 40; t++) begin
         tb = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 100));
         runs_q = {};
         rem = tb;
         while (rem > 0) begin
            r = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            if (r > rem && $urandom_range(0, 1) == 1) r = rem;
            runs_q.push_back(r);
            if (r > rem) rem = 0;
            else rem -= r;
         end
         xfer(tb, $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
